pipelined_mac_alu: RTL and testbench
====================================

// Module: pipelined_mac_alu
// PURPOSE
//  Next-generation FIR datapath ALU: 2-stage pipelined, parametrised-width signed ALU with
//  valid/ready handshakes, an internal accumulator (MAC), per-op wrap/saturate mode and a
//  sticky overflow flag. Sits between the FIR controller/register file and the result path.
//  It replaces the single-cycle combinational ALU so the multiply can be retimed.
// PARAMETERS
//  DATA_W  17  operand/result width, signed two's complement
//  FRAC_W  15  fractional bits of coefficient (src2) for MUL/MAC; product >>> FRAC_W
//  ACC_W   DATA_W  accumulator width (== DATA_W; saturation/overflow rules apply to it)
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  in_valid     in   1        command/operands valid
//  in_ready     out  1        ALU can accept a command this cycle
//  alu_op       in   3        alu_op_t: PASS=0 ADD=1 SUB=2 MUL=3 MAC=4 CLRACC=5 RDACC=6
//  sat_mode     in   1        1: saturate on overflow; 0: wrap (keep low DATA_W bits)
//  src1_data    in   DATA_W   signed sample / operand A
//  src2_data    in   DATA_W   signed coefficient (Q.FRAC_W for MUL/MAC) / operand B
//  out_valid    out  1        result valid
//  out_ready    in   1        consumer accepts result
//  result       out  DATA_W   signed result
//  overflow     out  1        overflow of this result (valid with out_valid)
//  ovf_sticky   out  1        OR of all overflows since reset/clear_sticky
//  clear_sticky in   1        synchronous clear of ovf_sticky (wins over same-cycle set)
// BEHAVIOUR
//  - Reset (async, rst=1): S1/S2 valid=0, acc=0, result=0, overflow=0, ovf_sticky=0,
//    out_valid=0; in_ready=1 on first cycle after release. Reset mid-op discards in-flight ops.
//  - Handshake: transfer on valid&ready each side. S2 advances when !s2_valid | out_ready;
//    S1 advances when !s1_valid | S2 advances; in_ready = that S1 condition. Latency 2 clk
//    in->out with no stall; throughput 1/clk. result/overflow held stable while out_valid&!out_ready.
//  - S1 (on accept): register op, sat_mode, and raw wide value: PASS a; ADD a+b (DATA_W+1);
//    SUB a-b (DATA_W+1); MUL/MAC (a*b)>>>FRAC_W, full 2*DATA_W signed product, arithmetic
//    shift (truncate toward -inf); CLRACC/RDACC raw=0.
//  - S2 (on S1->S2 transfer): PASS raw; ADD/SUB/MUL narrow raw; MAC narrow(acc + raw),
//    acc<=that value same edge; CLRACC acc<=0, result 0; RDACC result=acc.
//    Back-to-back MACs chain with no bubble (acc updated at S1->S2 transfer).
//  - narrow(x): overflow=1 iff x not in [-2^(DATA_W-1), 2^(DATA_W-1)-1]; sat_mode=1 clamps
//    to nearest bound, else low DATA_W bits. PASS/CLRACC/RDACC never overflow.
//  - ovf_sticky sets on S2 load with overflow=1; clear_sticky=1 forces 0 next edge.
//  - Stalled S2 holds: acc not updated again until the held MAC leaves (no double update).
//  - Undefined alu_op (7): treated as PASS, overflow=0.
// STRUCTURE
//  - alu_pkg: alu_op_t enum (3b), localparams for default widths, function sat_narrow().
//  - Sub-module alu_sat_narrow (param IN_W, OUT_W): combinational clamp/wrap + overflow;
//    instanced once in S2. Pipeline regs, acc and handshake stay in the top.
// TESTING (DATA_W=17, FRAC_W=15)
//  - MUL a=1000 b=0x04000(0.5), no stall -> out_valid 2 clk later, result=500, overflow=0.
//  - ADD 65535+1: sat_mode=0 -> -65536 ovf=1; sat_mode=1 -> 65535 ovf=1; ovf_sticky=1 until
//    clear_sticky.
//  - CLRACC, then MAC(100,0x08000) x3 back-to-back -> results 100,200,300; RDACC -> 300.
//  - out_ready=0 for 4 clk during 4-op burst: in_ready drops after 2 accepted, outputs
//    stable, all 4 results delivered in order, acc updated exactly once per MAC.
//  - MUL -32768*0x08000 (-1.0 scaled) and SUB -65536-1 sat -> -32768 ovf=0; -65536 ovf=1.
//  - rst pulse mid-burst (asynchronous, off clock edge) -> out_valid=0, acc=0 immediately;
//    next MAC(5,0x08000) -> 5.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode enum, default widths and the narrowing helper for the MAC ALU
package alu_pkg;

    localparam int DATA_W_DEF   = 17;
    localparam int FRAC_W_DEF   = 15;
    localparam int NARROW_W_DEF = 2 * DATA_W_DEF + 1;

    typedef enum logic [2:0] {
        OP_PASS   = 3'd0,
        OP_ADD    = 3'd1,
        OP_SUB    = 3'd2,
        OP_MUL    = 3'd3,
        OP_MAC    = 3'd4,
        OP_CLRACC = 3'd5,
        OP_RDACC  = 3'd6
    } alu_op_t;

    // Returns {overflow, narrowed value} for the default widths.
    function automatic logic [DATA_W_DEF:0] sat_narrow(
        input logic [NARROW_W_DEF-1:0] x,
        input logic                    sat
    );
        logic [NARROW_W_DEF-DATA_W_DEF:0] hi;
        logic                             ovf;
        logic [DATA_W_DEF-1:0]            y;
        hi  = x[NARROW_W_DEF-1:DATA_W_DEF-1];
        ovf = !((&hi) | ~(|hi));
        y   = x[DATA_W_DEF-1:0];
        if (ovf && sat) begin
            y = {x[NARROW_W_DEF-1], {(DATA_W_DEF-1){~x[NARROW_W_DEF-1]}}};
        end
        return {ovf, y};
    endfunction

endpackage

// File: rtl/alu_sat_narrow.sv
// rtl/alu_sat_narrow.sv - signed narrowing with overflow detect, clamp or wrap
module alu_sat_narrow #(
    parameter int IN_W  = 35,
    parameter int OUT_W = 17
) (
    input  logic [IN_W-1:0]  i_x,
    input  logic             i_sat,
    output logic [OUT_W-1:0] o_y,
    output logic             o_ovf
);

    // The value fits iff every bit from the target sign bit upward agrees.
    logic [IN_W-OUT_W:0] w_hi;
    logic                w_ovf;

    assign w_hi  = i_x[IN_W-1:OUT_W-1];
    assign w_ovf = !((&w_hi) | ~(|w_hi));

    assign o_ovf = w_ovf;
    assign o_y   = (w_ovf && i_sat) ? {i_x[IN_W-1], {(OUT_W-1){~i_x[IN_W-1]}}}
                                    : i_x[OUT_W-1:0];

endmodule

// File: rtl/pipelined_mac_alu.sv
// rtl/pipelined_mac_alu.sv - two-stage signed ALU with accumulator, saturation and handshakes
module pipelined_mac_alu
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               alu_op,
    input  logic                     sat_mode,
    input  logic signed [DATA_W-1:0] src1_data,
    input  logic signed [DATA_W-1:0] src2_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] result,
    output logic                     overflow,
    output logic                     ovf_sticky,
    input  logic                     clear_sticky
);

    localparam int RAW_W = 2 * DATA_W;
    localparam int NAR_W = RAW_W + 1;

    logic                    r_s1_valid;
    alu_op_t                 r_s1_op;
    logic                    r_s1_sat;
    logic signed [RAW_W-1:0] r_s1_raw;
    logic                    r_s2_valid;
    logic [DATA_W-1:0]       r_result;
    logic                    r_ovf;
    logic                    r_sticky;
    logic signed [DATA_W-1:0] r_acc;

    logic                    w_s2_adv;
    logic                    w_s1_adv;
    alu_op_t                 w_op;
    logic signed [RAW_W-1:0] w_a_ext;
    logic signed [RAW_W-1:0] w_b_ext;
    logic signed [RAW_W-1:0] w_prod;
    logic signed [RAW_W-1:0] w_raw;
    logic signed [NAR_W-1:0] w_nar_in;
    logic [DATA_W-1:0]       w_nar_res;
    logic                    w_nar_ovf;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    assign w_op    = alu_op_t'(alu_op);
    assign w_a_ext = RAW_W'(src1_data);
    assign w_b_ext = RAW_W'(src2_data);
    // Operands fit in DATA_W, so the low RAW_W bits hold the exact product.
    assign w_prod  = w_a_ext * w_b_ext;

    always_comb begin
        w_raw = w_a_ext;
        case (w_op)
            OP_ADD:              w_raw = w_a_ext + w_b_ext;
            OP_SUB:              w_raw = w_a_ext - w_b_ext;
            OP_MUL, OP_MAC:      w_raw = w_prod >>> FRAC_W;
            OP_CLRACC, OP_RDACC: w_raw = '0;
            default:             w_raw = w_a_ext;
        endcase
    end

    always_comb begin
        w_nar_in = NAR_W'(r_s1_raw);
        case (r_s1_op)
            OP_MAC:   w_nar_in = NAR_W'(r_acc) + NAR_W'(r_s1_raw);
            OP_RDACC: w_nar_in = NAR_W'(r_acc);
            default:  w_nar_in = NAR_W'(r_s1_raw);
        endcase
    end

    alu_sat_narrow #(
        .IN_W  (NAR_W),
        .OUT_W (DATA_W)
    ) u_narrow (
        .i_x   (w_nar_in),
        .i_sat (r_s1_sat),
        .o_y   (w_nar_res),
        .o_ovf (w_nar_ovf)
    );

    // acc only moves on the S1->S2 transfer, so a stalled MAC is applied once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_PASS;
            r_s1_sat   <= 1'b0;
            r_s1_raw   <= '0;
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_sticky   <= 1'b0;
            r_acc      <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_op  <= w_op;
                    r_s1_sat <= sat_mode;
                    r_s1_raw <= w_raw;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_result <= w_nar_res;
                    r_ovf    <= w_nar_ovf;
                    if (r_s1_op == OP_MAC) begin
                        r_acc <= w_nar_res;
                    end else if (r_s1_op == OP_CLRACC) begin
                        r_acc <= '0;
                    end
                end
            end
            if (clear_sticky) begin
                r_sticky <= 1'b0;
            end else if (w_s2_adv && r_s1_valid && w_nar_ovf) begin
                r_sticky <= 1'b1;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign result     = r_result;
    assign overflow   = r_ovf;
    assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_pipelined_mac_alu.sv
// tb/tb_pipelined_mac_alu.sv - scoreboard bench for the pipelined MAC ALU
module tb_pipelined_mac_alu;

    localparam logic [2:0] PASS = 3'd0, ADD = 3'd1, SUB = 3'd2, MUL = 3'd3;
    localparam logic [2:0] MAC = 3'd4, CLRACC = 3'd5, RDACC = 3'd6, UNDEF = 3'd7;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         alu_op;
    logic               sat_mode;
    logic signed [16:0] src1_data;
    logic signed [16:0] src2_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [16:0] result;
    logic               overflow;
    logic               ovf_sticky;
    logic               clear_sticky;

    typedef struct packed {
        logic signed [16:0] res;
        logic               ovf;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    pipelined_mac_alu #(.DATA_W(17), .FRAC_W(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_op       (alu_op),
        .sat_mode     (sat_mode),
        .src1_data    (src1_data),
        .src2_data    (src2_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .overflow     (overflow),
        .ovf_sticky   (ovf_sticky),
        .clear_sticky (clear_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: samples mid-low-phase, pops on each handshake, checks hold stability.
    logic               hold;
    logic signed [16:0] held_res;
    logic               held_ovf;
    initial begin
        exp_t e;
        hold = 1'b0;
        held_res = '0;
        held_ovf = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold && out_valid) begin
                    check("hold_result", int'(result), int'(held_res));
                    check("hold_overflow", int'(overflow), int'(held_ovf));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_output: got result %0d with empty scoreboard", result);
                    end else begin
                        e = sb.pop_front();
                        check("result", int'(result), int'(e.res));
                        check("overflow", int'(overflow), int'(e.ovf));
                    end
                end
                hold     = out_valid && !out_ready;
                held_res = result;
                held_ovf = overflow;
            end
        end
    end

    // Leaves in_valid high; the following send/idle call waits past the accepting edge.
    task automatic send(input logic [2:0] op, input logic sat, input int a, input int b,
                        input int er, input logic eo);
        int t;
        exp_t e;
        t = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        alu_op    = op;
        sat_mode  = sat;
        src1_data = a[16:0];
        src2_data = b[16:0];
        #1;
        while (!in_ready && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stayed 0 for op %0d", op);
        end else begin
            e.res = er[16:0];
            e.ovf = eo;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; alu_op = PASS; sat_mode = 1'b0;
        src1_data = '0; src2_data = '0; out_ready = 1'b1; clear_sticky = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_sticky", int'(ovf_sticky), 0);
        check("reset_result", int'(result), 0);
        check("reset_overflow", int'(overflow), 0);

        // Two-cycle latency on an unstalled MUL.
        send(MUL, 1'b0, 1000, 'h4000, 500, 1'b0);
        idle();
        #1;
        check("latency_1clk_out_valid", int'(out_valid), 0);
        @(negedge clk);
        #1;
        check("latency_2clk_out_valid", int'(out_valid), 1);
        drain();
        check("sticky_after_clean_mul", int'(ovf_sticky), 0);

        send(PASS, 1'b0, 12345, 7, 12345, 1'b0);
        send(UNDEF, 1'b1, -7, 99, -7, 1'b0);
        send(MUL, 1'b0, -1, 'h4000, -1, 1'b0);
        send(ADD, 1'b0, -100, 50, -50, 1'b0);
        idle();
        drain();

        send(ADD, 1'b0, 65535, 1, -65536, 1'b1);
        send(ADD, 1'b1, 65535, 1, 65535, 1'b1);
        send(SUB, 1'b0, -65536, 1, 65535, 1'b1);
        idle();
        drain();
        check("sticky_set", int'(ovf_sticky), 1);
        repeat (2) @(negedge clk);
        check("sticky_held", int'(ovf_sticky), 1);
        clear_sticky = 1'b1;
        @(negedge clk);
        clear_sticky = 1'b0;
        #1;
        check("sticky_cleared", int'(ovf_sticky), 0);

        send(CLRACC, 1'b0, 11, 22, 0, 1'b0);
        send(MAC, 1'b0, 100, 'h8000, 100, 1'b0);
        send(MAC, 1'b0, 100, 'h8000, 200, 1'b0);
        send(MAC, 1'b0, 100, 'h8000, 300, 1'b0);
        send(RDACC, 1'b0, 0, 0, 300, 1'b0);
        idle();
        drain();

        send(MUL, 1'b1, -32768, 'h8000, -32768, 1'b0);
        send(SUB, 1'b1, -65536, 1, -65536, 1'b1);
        idle();
        drain();

        // Stalled burst: consumer blocks for several clocks.
        send(CLRACC, 1'b0, 0, 0, 0, 1'b0);
        idle();
        drain();
        out_ready = 1'b0;
        send(MAC, 1'b0, 100, 'h8000, 100, 1'b0);
        send(MAC, 1'b0, 100, 'h8000, 200, 1'b0);
        idle();
        #1;
        check("stall_in_ready_low", int'(in_ready), 0);
        check("stall_out_valid", int'(out_valid), 1);
        fork
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join_none
        send(MAC, 1'b0, 100, 'h8000, 300, 1'b0);
        send(RDACC, 1'b0, 0, 0, 300, 1'b0);
        idle();
        drain();

        // Asynchronous reset mid-burst discards in-flight ops and the accumulator.
        out_ready = 1'b0;
        send(MAC, 1'b0, 7, 'h8000, 307, 1'b0);
        send(ADD, 1'b0, 65535, 1, -65536, 1'b1);
        idle();
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_sticky", int'(ovf_sticky), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);
        send(MAC, 1'b0, 5, 'h8000, 5, 1'b0);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
